writeback_stage_p: RTL
======================

# writeback_stage_p

Parametrised, registered writeback stage for the MIPS pipeline, sitting between the MEM/WB boundary and the register file write port. It selects the result source (ALU, data memory, or link address) and the destination register (rt, rd, or $31). It extracts and extends sub-word load data and suppresses writes to $0 and misaligned loads. It also exposes a forwarding tap and a retired-instruction counter.

## Interface
- DATA_W, 32, datapath width (≥16, multiple of 16)
- REG_AW, 5, register address width
- CNT_W, 32, retired-instruction counter width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  MEM stage presents a valid instruction this cycle
- flush  in  1  kill the instruction presented this cycle
- o  in  DATA_W  ALU result
- d  in  DATA_W  DMEM read word
- pc  in  DATA_W  PC of the instruction
- insn  in  32  instruction word
- rwd  in  2  result select: 0 ALU, 1 DMEM, 2 link (pc+8), 3 reserved (treated as 0)
- rdst  in  2  destination select: 0 insn[20:16], 1 insn[15:11], 2 register 31, 3 reserved (treated as 0)
- rwe  in  1  instruction writes the register file
- lsz  in  2  load size: 0 byte, 1 half, 2/3 word
- lsign  in  1  sign-extend a sub-word load
- boff  in  2  byte offset, o[1:0] of the load address
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_AW  register file write address
- rf_wdata  out  DATA_W  register file write data
- fwd_valid  out  1  forwarding tap valid, equal to rf_we
- wb_misalign  out  1  registered misaligned-load flag
- retired  out  CNT_W  count of retired instructions

## Operation
- One pipeline register, loaded every cycle. It takes the presented instruction when in_valid & !flush; otherwise it takes a bubble (valid=0).
- Captured: valid, write enable, destination address, result data, misalign flag.
- Destination address: selected by rdst, then zero-extended or truncated to REG_AW.
- Result data, rwd=0: o.
- Result data, rwd=2: pc+8, modulo 2^DATA_W.
- Result data, rwd=1, word: d unchanged.
- Result data, rwd=1, byte: big-endian lane. boff=0 takes d[31:24], boff=3 takes d[7:0]. Result is sign- or zero-extended to DATA_W per lsign.
- Result data, rwd=1, half: boff[1]=0 takes d[31:16], else d[15:0]; then extended as for byte.
- Misalign: rwd=1 & lsz=1 & boff[0]=1, or rwd=1 & lsz≥2 & boff≠0.
- Effective write enable = valid & rwe & (addr≠0) & !misalign.
- rf_we and fwd_valid are driven from the registered write enable.
- wb_misalign = registered valid & misalign.
- retired increments by 1 each cycle the registered valid is 1, whether or not a write occurs. It wraps from 2^CNT_W−1 to 0.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on rf_* at edge N+1 and hold for exactly one cycle unless the next instruction also writes.
- No backpressure. The upstream stage re-presents a held instruction with in_valid=0 so it is not written twice.
- flush has priority over in_valid in the same cycle.
- Reset: all registered state goes to 0. rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, wb_misalign=0, retired=0.
- Reset asserted mid-stream discards the in-flight instruction; nothing is written on the reset edge.
- Back-to-back writes to the same register are both issued in consecutive cycles. Last writer wins at the register file.

## Configuration
- WB_LOAD_EXT_EN defined: byte/half extraction, extension, and misalign detection are compiled in as described.
- WB_LOAD_EXT_EN undefined: lsz, lsign and boff are ignored. rwd=1 forwards d unchanged, and misalign is constant 0.

## Test plan
- Reset, then in_valid=1, rwd=0, rdst=1, insn[15:11]=5, o=0x1234_5678, rwe=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678; retired=1.
- Load byte: rwd=1, lsz=0, lsign=1, boff=2, d=0x00FF_8000 -> rf_wdata=0xFFFF_FF80. Same with lsign=0 -> 0x0000_0080.
- Half load at boff=1 -> rf_we=0, wb_misalign=1, retired still increments. Word load at boff=0 -> rf_wdata=d.
- JAL-style: rwd=2, rdst=2, pc=0x0040_0010 -> rf_waddr=31, rf_wdata=0x0040_0018. Destination $0 with rwe=1 -> rf_we=0.
- flush=1 with in_valid=1 -> rf_we=0 and retired unchanged. Reset asserted the cycle after a valid write is captured -> outputs 0, counter 0.
- CNT_W=4: 16 valid instructions -> retired wraps to 0. Build without WB_LOAD_EXT_EN: byte load with d=0xAABB_CCDD -> rf_wdata=0xAABB_CCDD.

Source files
------------

// File: rtl/writeback_stage_p.sv
// writeback_stage_p: registered MIPS writeback stage between MEM/WB and the
// register file write port. Selects result source and destination register,
// extracts/extends sub-word loads, suppresses $0 and misaligned-load writes,
// and counts retired instructions.
// Optional feature macro: WB_LOAD_EXT_EN (byte/half extraction, extension and
// misalign detection). Without it, rwd=1 forwards d unchanged and no load is
// ever flagged misaligned.
module writeback_stage_p #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [DATA_W-1:0] o,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] pc,
    input  logic [31:0]       insn,
    input  logic [1:0]        rwd,
    input  logic [1:0]        rdst,
    input  logic              rwe,
    input  logic [1:0]        lsz,
    input  logic              lsign,
    input  logic [1:0]        boff,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic              wb_misalign,
    output logic [CNT_W-1:0]  retired
);

    logic              take_s;
    logic [4:0]        sel5_s;
    logic [REG_AW-1:0] addr_s;
    logic [DATA_W-1:0] load_s;
    logic [DATA_W-1:0] res_s;
    logic              mis_s;

    logic              we_d,    we_q;
    logic [REG_AW-1:0] waddr_d, waddr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    logic              mis_d,   mis_q;
    logic [CNT_W-1:0]  cnt_d,   cnt_q;

    // Instruction fields that never influence writeback.
    logic unused_insn_s;
    assign unused_insn_s = ^{insn[31:21], insn[10:0]};

`ifdef WB_LOAD_EXT_EN
    // Big-endian lanes are always taken from a 32-bit view of the read word.
    logic [31:0] dw_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    if (DATA_W >= 32) begin : g_dw_wide
        assign dw_s = d[31:0];
    end else begin : g_dw_narrow
        assign dw_s = {{(32-DATA_W){1'b0}}, d};
    end

    // Sub-word lane extraction, extension and misalign detection.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        load_s = d;
        mis_s  = 1'b0;
        case (boff)
            2'd0:    byte_s = dw_s[31:24];
            2'd1:    byte_s = dw_s[23:16];
            2'd2:    byte_s = dw_s[15:8];
            default: byte_s = dw_s[7:0];
        endcase
        if (boff[1]) begin
            half_s = dw_s[15:0];
        end else begin
            half_s = dw_s[31:16];
        end
        case (lsz)
            2'd0: begin
                load_s = DATA_W'(byte_s) |
                         ((lsign & byte_s[7]) ? ~DATA_W'(8'hFF) : {DATA_W{1'b0}});
                mis_s  = 1'b0;
            end
            2'd1: begin
                load_s = DATA_W'(half_s) |
                         ((lsign & half_s[15]) ? ~DATA_W'(16'hFFFF) : {DATA_W{1'b0}});
                mis_s  = boff[0];
            end
            default: begin
                load_s = d;
                mis_s  = (boff != 2'd0);
            end
        endcase
        if (rwd != 2'd1) begin
            mis_s = 1'b0;
        end else begin
            mis_s = mis_s;
        end
    end
`else
    // Load-size controls are ignored in this build.
    logic unused_load_s;
    assign unused_load_s = ^{lsz, lsign, boff};
    assign load_s        = d;
    assign mis_s         = 1'b0;
`endif

    // Destination/result selection and next state of the pipeline register.
    always_comb begin
        take_s = in_valid & ~flush;
        case (rdst)
            2'd1:    sel5_s = insn[15:11];
            2'd2:    sel5_s = 5'd31;
            default: sel5_s = insn[20:16];
        endcase
        addr_s = REG_AW'(sel5_s);
        case (rwd)
            2'd1:    res_s = load_s;
            2'd2:    res_s = pc + DATA_W'(32'd8);
            default: res_s = o;
        endcase
        if (take_s) begin
            we_d    = rwe & (addr_s != {REG_AW{1'b0}}) & ~mis_s;
            waddr_d = addr_s;
            wdata_d = res_s;
            mis_d   = mis_s;
            cnt_d   = cnt_q + CNT_W'(32'd1);
        end else begin
            we_d    = 1'b0;
            waddr_d = {REG_AW{1'b0}};
            wdata_d = {DATA_W{1'b0}};
            mis_d   = 1'b0;
            cnt_d   = cnt_q;
        end
    end

    // Pipeline register with synchronous reset; a bubble clears the slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q    <= 1'b0;
            waddr_q <= {REG_AW{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            mis_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rf_we       = we_q;
    assign fwd_valid   = we_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign wb_misalign = mis_q;
    assign retired     = cnt_q;

endmodule
